spi_gyro_responder: RTL and testbench

SPI_GYRO_RESPONDER -- requirements
Module: spi_gyro_responder

---
 rtl/spi_gyro_responder_pkg.sv | 19 +
 rtl/sync_2ff.sv | 16 +
 rtl/spi_gyro_responder.sv | 155 +++++++++++++++
 tb/tb_spi_gyro_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_gyro_responder_pkg.sv
// spi_gyro_responder_pkg: register map and transaction states shared by the gyro responder and master-side controller
package spi_gyro_responder_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_e;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H  = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L  = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H  = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L  = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;

    function automatic logic [5:0] next_addr(input logic [5:0] a, input logic ms);
        return ms ? a + 6'd1 : a;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input, with a chosen idle value in reset
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q_o, meta_q} <= {2{RST_VAL}};
        else     {q_o, meta_q} <= {meta_q, d_i};
    end
endmodule

// File: rtl/spi_gyro_responder.sv
// spi_gyro_responder: SPI mode-3 slave exposing a gyro-style register map, oversampled on clk.
module spi_gyro_responder
    import spi_gyro_responder_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0] CTRL1_RST    = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] x_axis_in,
    input  logic [15:0] y_axis_in,
    input  logic [15:0] z_axis_in,
    input  logic        sample_valid,
    output logic [7:0]  ctrl_reg1,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr
);
    logic cs_s, sclk_s, mosi_s;

    sync_2ff #(.RST_VAL(1'b1)) u_cs_sync   (.clk(clk), .rst(rst), .d_i(cs),   .q_o(cs_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sclk_sync (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
    sync_2ff #(.RST_VAL(1'b0)) u_mosi_sync (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));

    spi_state_e  state_q, state_d;
    logic        cs_q, sclk_q, arm_q;
    logic [1:0]  settle_q;
    logic [2:0]  bit_q;
    logic [6:0]  rx_q;
    logic [7:0]  tx_q, ctrl_q, rd_byte, rx_byte;
    logic        rw_q, ms_q, load_q, miso_q, wr_q;
    logic [5:0]  addr_q, wr_addr_q;
    logic [15:0] live_x_q, live_y_q, live_z_q, snap_x_q, snap_y_q, snap_z_q;
    logic        active, cs_fall, cs_rise, sc_rise, sc_fall, byte_done;

    // arm_q keeps a cs held low across reset release from looking like a new falling edge
    assign cs_fall   = arm_q & cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign active    = (state_q != IDLE) & ~cs_s;
    assign sc_rise   = active & ~sclk_q & sclk_s;
    assign sc_fall   = active & sclk_q & ~sclk_s;
    assign byte_done = sc_rise & (bit_q == 3'd7);
    assign rx_byte   = {rx_q, mosi_s};

    assign miso      = miso_q;
    assign miso_oe   = ~cs_s;
    assign ctrl_reg1 = ctrl_q;
    assign wr_strobe = wr_q;
    assign wr_addr   = wr_addr_q;

    always_comb begin
        case (addr_q)
            ADDR_WHO_AM_I: rd_byte = WHO_AM_I_VAL;
            ADDR_CTRL1:    rd_byte = ctrl_q;
            ADDR_OUT_X_L:  rd_byte = snap_x_q[7:0];
            ADDR_OUT_X_H:  rd_byte = snap_x_q[15:8];
            ADDR_OUT_Y_L:  rd_byte = snap_y_q[7:0];
            ADDR_OUT_Y_H:  rd_byte = snap_y_q[15:8];
            ADDR_OUT_Z_L:  rd_byte = snap_z_q[7:0];
            ADDR_OUT_Z_H:  rd_byte = snap_z_q[15:8];
            default:       rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise)                           state_d = IDLE;
        else if (cs_fall)                      state_d = CMD;
        else if (state_q == CMD && byte_done)  state_d = DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q      <= 1'b1;
            sclk_q    <= 1'b1;
            arm_q     <= 1'b0;
            settle_q  <= 2'd0;
            bit_q     <= 3'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            rw_q      <= 1'b0;
            ms_q      <= 1'b0;
            load_q    <= 1'b0;
            addr_q    <= 6'd0;
            miso_q    <= 1'b0;
            ctrl_q    <= CTRL1_RST;
            wr_q      <= 1'b0;
            wr_addr_q <= 6'd0;
            live_x_q  <= 16'd0;
            live_y_q  <= 16'd0;
            live_z_q  <= 16'd0;
            snap_x_q  <= 16'd0;
            snap_y_q  <= 16'd0;
            snap_z_q  <= 16'd0;
        end else begin
            cs_q     <= cs_s;
            sclk_q   <= sclk_s;
            settle_q <= (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
            arm_q    <= arm_q | ((settle_q == 2'd2) & cs_s);
            wr_q     <= 1'b0;
            if (sample_valid) begin
                live_x_q <= x_axis_in;
                live_y_q <= y_axis_in;
                live_z_q <= z_axis_in;
            end
            if (cs_fall) begin
                snap_x_q <= live_x_q;
                snap_y_q <= live_y_q;
                snap_z_q <= live_z_q;
                bit_q    <= 3'd0;
                load_q   <= 1'b0;
                miso_q   <= 1'b0;
                tx_q     <= 8'd0;
            end else if (cs_rise) begin
                bit_q    <= 3'd0;
                load_q   <= 1'b0;
                miso_q   <= 1'b0;
            end else begin
                if (sc_rise) begin
                    bit_q <= bit_q + 3'd1;
                    rx_q  <= rx_byte[6:0];
                end
                if (byte_done && state_q == CMD) begin
                    rw_q   <= rx_byte[7];
                    ms_q   <= rx_byte[6];
                    addr_q <= rx_byte[5:0];
                    load_q <= rx_byte[7];
                end else if (byte_done) begin
                    load_q <= rw_q;
                    addr_q <= next_addr(addr_q, ms_q);
                    if (!rw_q) begin
                        wr_q      <= 1'b1;
                        wr_addr_q <= addr_q;
                        if (addr_q == ADDR_CTRL1) ctrl_q <= rx_byte;
                    end
                end
                // a pending read loads on the first falling edge of the next byte
                if (sc_fall) begin
                    miso_q <= load_q ? rd_byte[7] : tx_q[7];
                    tx_q   <= load_q ? {rd_byte[6:0], 1'b0} : {tx_q[6:0], 1'b0};
                    load_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_gyro_responder.sv
// tb_spi_gyro_responder: drives SPI mode-3 transactions at sclk = clk/8 and scores miso bytes and register side effects.
module tb_spi_gyro_responder;
    logic        clk = 1'b0;
    logic        rst, cs, sclk, mosi, sample_valid;
    logic [15:0] x_axis_in, y_axis_in, z_axis_in;
    logic        miso, miso_oe, wr_strobe;
    logic [7:0]  ctrl_reg1;
    logic [5:0]  wr_addr;

    int          total = 0, bad = 0;
    logic [7:0]  txq[$], expq[$];
    int          pulse_at = -1;
    logic [15:0] nx, ny, nz;
    int          stb_n = 0;
    logic [5:0]  stb_addr = 6'd0;
    int          s0;
    logic [7:0]  r;

    spi_gyro_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .x_axis_in(x_axis_in), .y_axis_in(y_axis_in), .z_axis_in(z_axis_in),
        .sample_valid(sample_valid), .ctrl_reg1(ctrl_reg1),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            stb_n    <= stb_n + 1;
            stb_addr <= wr_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_axis_in = x; y_axis_in = y; z_axis_in = z;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] rb);
        rb = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sclk = 1'b0;
            mosi = b[i];
            tick(4);
            rb[i] = miso;
            sclk = 1'b1;
            tick(4);
        end
    endtask

    task automatic run_xact(input string tag);
        logic [7:0] b, rb, e;
        int idx = 0;
        cs = 1'b0;
        tick(4);
        chk({tag, "_oe_on"}, miso_oe, 1);
        while (txq.size() > 0) begin
            b = txq.pop_front();
            if (idx == pulse_at) load_sample(nx, ny, nz);
            send_byte(b, 8, rb);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk($sformatf("%s_b%0d", tag, idx), rb, e);
            end
            idx++;
        end
        tick(4);
        cs = 1'b1;
        tick(6);
        chk({tag, "_oe_off"}, miso_oe, 0);
        chk({tag, "_sb_left"}, expq.size(), 0);
        tick(4);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b1; mosi = 1'b0; sample_valid = 1'b0;
        x_axis_in = 16'h0; y_axis_in = 16'h0; z_axis_in = 16'h0;
        tick(3);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_ctrl", ctrl_reg1, 8'h07);
        chk("rst_stb", wr_strobe, 0);
        chk("rst_waddr", wr_addr, 0);
        rst = 1'b0;
        tick(5);

        txq = '{8'h8F, 8'h00}; expq = '{8'h00, 8'hD3};
        run_xact("whoami");

        load_sample(16'h1234, 16'hABCD, 16'h8001);
        nx = 16'h5566; ny = 16'h7788; nz = 16'h99AA; pulse_at = 3;
        txq = '{8'hE8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expq = '{8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
        run_xact("burst1");
        pulse_at = -1;
        txq = '{8'hE8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expq = '{8'h00, 8'h66, 8'h55, 8'h88, 8'h77, 8'hAA, 8'h99};
        run_xact("burst2");

        s0 = stb_n;
        txq = '{8'h20, 8'h0F}; expq = '{8'h00, 8'h00};
        run_xact("wr_ctrl");
        chk("wr_ctrl_stb", stb_n - s0, 1);
        chk("wr_ctrl_addr", stb_addr, 6'h20);
        chk("wr_ctrl_val", ctrl_reg1, 8'h0F);

        s0 = stb_n;
        txq = '{8'h0F, 8'h55}; expq = '{8'h00, 8'h00};
        run_xact("wr_who");
        chk("wr_who_stb", stb_n - s0, 1);
        chk("wr_who_addr", stb_addr, 6'h0F);
        chk("wr_who_ctrl", ctrl_reg1, 8'h0F);
        txq = '{8'h8F, 8'h00}; expq = '{8'h00, 8'hD3};
        run_xact("who_after");

        txq = '{8'hFF, 8'h00, 8'h00}; expq = '{8'h00, 8'h00, 8'h00};
        run_xact("wrap");
        txq = '{8'hE0, 8'h00, 8'h00}; expq = '{8'h00, 8'h0F, 8'h00};
        run_xact("inc_ctrl");
        txq = '{8'hA8, 8'h00, 8'h00}; expq = '{8'h00, 8'h66, 8'h66};
        run_xact("fixed");

        s0 = stb_n;
        cs = 1'b0;
        tick(4);
        send_byte(8'h20, 8, r);
        send_byte(8'hAA, 4, r);
        tick(4);
        cs = 1'b1;
        tick(8);
        chk("part_ctrl", ctrl_reg1, 8'h0F);
        chk("part_stb", stb_n - s0, 0);

        cs = 1'b0;
        tick(4);
        send_byte(8'h8F, 8, r);
        send_byte(8'h00, 2, r);
        chk("pre_rst_miso", miso, 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_oe", miso_oe, 0);
        chk("mid_rst_ctrl", ctrl_reg1, 8'h07);
        chk("mid_rst_stb", wr_strobe, 0);
        chk("mid_rst_waddr", wr_addr, 0);
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("post_rst_oe", miso_oe, 1);
        cs = 1'b1;
        tick(8);
        txq = '{8'h8F, 8'h00}; expq = '{8'h00, 8'hD3};
        run_xact("post_rst_who");
        txq = '{8'hA0, 8'h00}; expq = '{8'h00, 8'h07};
        run_xact("post_rst_ctrl");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
